// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the combination-lock sequencing controller.
//   - lock_state_e : 3-bit state encoding, also consumed by the 7-segment LED decoder
//   - LED_*        : 7-segment patterns ({g,f,e,d,c,b,a}, active high) per state
//   - led_pattern  : state code -> LED pattern
//   - max_int      : helper for sizing the shared timer
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_CHG_WAIT = 3'b001,
    ST_LOCKOUT  = 3'b010,
    ST_ALARM    = 3'b011,
    ST_OPEN     = 3'b100
  } lock_state_e;

  localparam logic [6:0] LED_IDLE  = 7'b1000000;  // '-'
  localparam logic [6:0] LED_CHG   = 7'b0111001;  // 'C'
  localparam logic [6:0] LED_OPEN  = 7'b0111111;  // 'O'
  localparam logic [6:0] LED_LOCK  = 7'b0111000;  // 'L'
  localparam logic [6:0] LED_ALARM = 7'b1110111;  // 'A'
  localparam logic [6:0] LED_BLANK = 7'b0000000;  // unused codes

  function automatic logic [6:0] led_pattern(input logic [2:0] code);
    logic [6:0] pat;
    case (code)
      3'b000:  pat = LED_IDLE;
      3'b001:  pat = LED_CHG;
      3'b100:  pat = LED_OPEN;
      3'b010:  pat = LED_LOCK;
      3'b011:  pat = LED_ALARM;
      default: pat = LED_BLANK;
    endcase
    return pat;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter shared by the OPEN/CHG_WAIT timeout and
// the LOCKOUT window.
//   Clock, Resetn : clock / async active-low reset
//   load          : capture 'value' into the counter (wins over clear)
//   clear         : force the counter to 0 (used outside timed states)
//   value         : load value (number of cycles to spend in the timed state)
//   expire        : high during the last cycle of the window (counter == 1)
// The counter stops at 0 and never wraps.
module lock_timer
  import lock_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count_r;

  // Down-counter: load, clear, or decrement toward 0 and hold there
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= value;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_r != '0) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == W'(1));

endmodule

// File: rtl/lock_attempt_ctrl.sv
// lock_attempt_ctrl: sequencing controller between the debounced keypad pulses
// and the combination-lock datapath.
//   Clock, Resetn  : clock / async active-low reset
//   enterpulse     : one-cycle enter strobe
//   changepulse    : one-cycle change strobe (wins over enter when both high)
//   correct        : password == combo, sampled together with a pulse
//   admin_clear    : level, releases ALARM only
//   open_lock      : high while OPEN
//   load_combo     : one-cycle strobe, datapath captures password as new combo
//   alarm, lockout : high while in ALARM / LOCKOUT
//   state          : encoded state for the LED decoder (see lock_pkg)
//   fail_count     : consecutive wrong attempts, never shows MAX_TRIES
// All outputs are registered; a response appears one cycle after the pulse.
module lock_attempt_ctrl
  import lock_pkg::*;
#(
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int OPEN_CYCLES    = 500
) (
  input  logic                               Clock,
  input  logic                               Resetn,
  input  logic                               enterpulse,
  input  logic                               changepulse,
  input  logic                               correct,
  input  logic                               admin_clear,
  output logic                               open_lock,
  output logic                               load_combo,
  output logic                               alarm,
  output logic                               lockout,
  output logic [2:0]                         state,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count
);

  localparam int FCW = $clog2(MAX_TRIES + 1);
  localparam int TW  = $clog2(max_int(LOCKOUT_CYCLES, OPEN_CYCLES) + 1);

  localparam logic [FCW-1:0] FAIL_SAT  = FCW'(MAX_TRIES - 1);
  localparam logic [TW-1:0]  OPEN_LOAD = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0]  LOCK_LOAD = TW'(LOCKOUT_CYCLES);

  lock_state_e     state_r, state_nxt_s;
  logic [FCW-1:0]  fail_r, fail_nxt_s;
  logic            strike_r, strike_nxt_s;
  logic            load_nxt_s;
  logic            open_lock_r, load_combo_r, alarm_r, lockout_r;

  logic            attempt_s;
  logic            fail_limit_s;
  logic            tmr_load_s, tmr_clear_s, tmr_expire_s;
  logic [TW-1:0]   tmr_value_s;

  assign attempt_s    = enterpulse | changepulse;
  // This wrong attempt would make the visible count reach MAX_TRIES.
  assign fail_limit_s = ((int'(fail_r) + 1) >= MAX_TRIES);

  lock_timer #(.W(TW)) u_timer (
    .Clock  (Clock),
    .Resetn (Resetn),
    .load   (tmr_load_s),
    .clear  (tmr_clear_s),
    .value  (tmr_value_s),
    .expire (tmr_expire_s)
  );

  // Next-state, counter, strike and timer-control decode
  always_comb begin
    state_nxt_s  = state_r;
    fail_nxt_s   = fail_r;
    strike_nxt_s = strike_r;
    load_nxt_s   = 1'b0;
    tmr_load_s   = 1'b0;
    tmr_value_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (changepulse && correct) begin
          state_nxt_s = ST_CHG_WAIT;
          fail_nxt_s  = '0;
          tmr_load_s  = 1'b1;
          tmr_value_s = OPEN_LOAD;
        end else if (enterpulse && correct) begin
          state_nxt_s  = ST_OPEN;
          fail_nxt_s   = '0;
          strike_nxt_s = 1'b0;
          tmr_load_s   = 1'b1;
          tmr_value_s  = OPEN_LOAD;
        end else if (attempt_s) begin
          if (!fail_limit_s) begin
            fail_nxt_s = fail_r + FCW'(1);
          end else if (strike_r) begin
            // Second exhausted round: sticky alarm, count shown saturated.
            state_nxt_s = ST_ALARM;
            fail_nxt_s  = FAIL_SAT;
          end else begin
            state_nxt_s  = ST_LOCKOUT;
            strike_nxt_s = 1'b1;
            fail_nxt_s   = '0;
            tmr_load_s   = 1'b1;
            tmr_value_s  = LOCK_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CHG_WAIT: begin
        // Any pulse accepts the new combo; a pulse on the expiry cycle still loads.
        if (attempt_s) begin
          load_nxt_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (tmr_expire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CHG_WAIT;
        end
      end
      ST_OPEN: begin
        if (enterpulse || tmr_expire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_expire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOCKOUT;
        end
      end
      ST_ALARM: begin
        if (admin_clear) begin
          state_nxt_s  = ST_IDLE;
          fail_nxt_s   = '0;
          strike_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_ALARM;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        fail_nxt_s   = '0;
        strike_nxt_s = 1'b0;
      end
    endcase
    // Timer rests at 0 whenever the next state is untimed.
    tmr_clear_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ALARM);
  end

  // State, counters and registered status outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r      <= ST_IDLE;
      fail_r       <= '0;
      strike_r     <= 1'b0;
      open_lock_r  <= 1'b0;
      load_combo_r <= 1'b0;
      alarm_r      <= 1'b0;
      lockout_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fail_r       <= fail_nxt_s;
      strike_r     <= strike_nxt_s;
      open_lock_r  <= (state_nxt_s == ST_OPEN);
      load_combo_r <= load_nxt_s;
      alarm_r      <= (state_nxt_s == ST_ALARM);
      lockout_r    <= (state_nxt_s == ST_LOCKOUT);
    end
  end

  assign open_lock  = open_lock_r;
  assign load_combo = load_combo_r;
  assign alarm      = alarm_r;
  assign lockout    = lockout_r;
  assign state      = state_r;
  assign fail_count = fail_r;

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Self-checking bench for lock_attempt_ctrl (MAX_TRIES=3, LOCKOUT_CYCLES=8,
// OPEN_CYCLES=5). A behavioural model tracks the lock mode with an absolute
// deadline in cycles; a compare process checks every output each cycle, and
// the directed scenarios add literal expectations.
module tb_lock_attempt_ctrl;

  localparam int MT = 3;
  localparam int LC = 8;
  localparam int OC = 5;

  localparam int MD_IDLE  = 0;
  localparam int MD_CHG   = 1;
  localparam int MD_OPEN  = 2;
  localparam int MD_LOCK  = 3;
  localparam int MD_ALARM = 4;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b1;
  logic       enterpulse = 1'b0, changepulse = 1'b0, correct = 1'b0, admin_clear = 1'b0;
  logic       open_lock, load_combo, alarm, lockout;
  logic [2:0] state;
  logic [1:0] fail_count;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  lock_attempt_ctrl #(.MAX_TRIES(MT), .LOCKOUT_CYCLES(LC), .OPEN_CYCLES(OC)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .enterpulse  (enterpulse),
    .changepulse (changepulse),
    .correct     (correct),
    .admin_clear (admin_clear),
    .open_lock   (open_lock),
    .load_combo  (load_combo),
    .alarm       (alarm),
    .lockout     (lockout),
    .state       (state),
    .fail_count  (fail_count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode = MD_IDLE;
  int m_fails = 0;
  int m_cyc = 0;
  int m_deadline = 0;
  bit m_strike = 1'b0;
  bit m_load = 1'b0;

  function automatic int code_of(input int md);
    case (md)
      MD_CHG:   return 1;
      MD_OPEN:  return 4;
      MD_LOCK:  return 2;
      MD_ALARM: return 3;
      default:  return 0;
    endcase
  endfunction

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_mode = MD_IDLE; m_fails = 0; m_strike = 1'b0; m_load = 1'b0;
      m_cyc = 0; m_deadline = 0;
    end else begin
      m_cyc++;
      m_load = 1'b0;
      case (m_mode)
        MD_IDLE: begin
          if (enterpulse || changepulse) begin
            if (correct && changepulse) begin
              m_mode = MD_CHG; m_fails = 0; m_deadline = m_cyc + OC;
            end else if (correct) begin
              m_mode = MD_OPEN; m_fails = 0; m_strike = 1'b0; m_deadline = m_cyc + OC;
            end else begin
              m_fails++;
              if (m_fails == MT) begin
                if (!m_strike) begin
                  m_mode = MD_LOCK; m_strike = 1'b1; m_fails = 0; m_deadline = m_cyc + LC;
                end else begin
                  m_mode = MD_ALARM; m_fails = MT - 1;
                end
              end
            end
          end
        end
        MD_CHG: begin
          if (enterpulse || changepulse) begin
            m_load = 1'b1; m_mode = MD_IDLE;
          end else if (m_cyc == m_deadline) begin
            m_mode = MD_IDLE;
          end
        end
        MD_OPEN:  if (enterpulse || m_cyc == m_deadline) m_mode = MD_IDLE;
        MD_LOCK:  if (m_cyc == m_deadline) m_mode = MD_IDLE;
        MD_ALARM: if (admin_clear) begin m_mode = MD_IDLE; m_fails = 0; m_strike = 1'b0; end
        default:  m_mode = MD_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clock) begin
    if (cmp_en) begin
      check("state", state, code_of(m_mode));
      check("open_lock", open_lock, (m_mode == MD_OPEN) ? 1 : 0);
      check("alarm", alarm, (m_mode == MD_ALARM) ? 1 : 0);
      check("lockout", lockout, (m_mode == MD_LOCK) ? 1 : 0);
      check("load_combo", load_combo, m_load ? 1 : 0);
      check("fail_count", fail_count, m_fails);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit e, input bit c, input bit k, input bit a);
    @(negedge Clock);
    enterpulse = e; changepulse = c; correct = k; admin_clear = a;
    @(negedge Clock);
    enterpulse = 1'b0; changepulse = 1'b0; correct = 1'b0; admin_clear = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge Clock);
  endtask

  int loads;

  initial begin
    #1 Resetn = 1'b0;
    cmp_en = 1'b1;
    wait_neg(2);
    #2 Resetn = 1'b1;
    wait_neg(1);
    check("rst_state", state, 0);
    check("rst_open", open_lock, 0);
    check("rst_fail", fail_count, 0);

    // correct enter opens, auto-relock after 5 cycles
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check("open_state", state, 3'b100);
    check("open_lock_on", open_lock, 1);
    wait_neg(4);
    check("open_still", open_lock, 1);
    wait_neg(1);
    check("open_relock", open_lock, 0);
    check("open_to_idle", state, 0);

    // three wrong attempts -> lockout, pulses dropped, back after 8 cycles
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("fail1", fail_count, 1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("fail2", fail_count, 2);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("lockout_on", lockout, 1);
    check("lockout_fail0", fail_count, 0);
    check("lockout_state", state, 3'b010);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("lockout_drop", fail_count, 0);
    wait_neg(3);
    check("lockout_last", lockout, 1);
    wait_neg(1);
    check("lockout_end", state, 0);

    // second round -> alarm, sticky until admin_clear
    repeat (3) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("alarm_on", alarm, 1);
    check("alarm_state", state, 3'b011);
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check("alarm_sticky", state, 3'b011);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("alarm_clear_state", state, 0);
    check("alarm_clear_alarm", alarm, 0);

    // change with correct, then enter loads combo
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("chg_state", state, 3'b001);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("chg_load", load_combo, 1);
    check("chg_back_idle", state, 0);
    wait_neg(1);
    check("chg_load_once", load_combo, 0);

    // change abandoned: 5 cycles then idle, never loads
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("chg2_state", state, 3'b001);
    loads = 0;
    repeat (5) begin
      @(negedge Clock);
      loads += int'(load_combo);
    end
    check("chg2_timeout", state, 0);
    check("chg2_noload", loads, 0);

    // both pulses together: change wins
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    check("both_chg", state, 3'b001);
    check("both_not_open", open_lock, 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("both_load", load_combo, 1);

    // reset mid-OPEN drops everything before the next edge
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    wait_neg(1);
    check("pre_rst_open", open_lock, 1);
    #2 Resetn = 1'b0;
    #1;
    check("rst_async_open", open_lock, 0);
    check("rst_async_state", state, 0);
    check("rst_async_misc", {load_combo, alarm, lockout}, 0);
    check("rst_async_fail", fail_count, 0);
    wait_neg(1);
    #2 Resetn = 1'b1;

    // randomized traffic against the model
    repeat (3000) begin
      @(negedge Clock);
      enterpulse  = ($urandom_range(0, 99) < 20);
      changepulse = ($urandom_range(0, 99) < 10);
      correct     = ($urandom_range(0, 99) < 40);
      admin_clear = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 499) == 0) begin
        #2 Resetn = 1'b0;
        @(negedge Clock);
        #2 Resetn = 1'b1;
      end
    end
    @(negedge Clock);
    enterpulse = 1'b0; changepulse = 1'b0; correct = 1'b0; admin_clear = 1'b0;
    wait_neg(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
